gate_checker: RTL

GATE_CHECKER -- requirements
Module: gate_checker

---
 rtl/gate_checker.sv | 131 +++++++++++++
 1 files changed

// File: rtl/gate_checker.sv
// gate_checker: drives all four input vectors to a 2-input gate, holds each for
// SETTLE cycles, samples the gate output and compares it with the EXPECT truth table.
module gate_checker #(
  parameter logic [3:0]  EXPECT = 4'b1110,
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       c_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] err_mask
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned ERR_W   = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       err_mask_q, err_mask_d;
  logic             a_out_q, a_out_d;
  logic             b_out_q, b_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  // Next-state, sequencing and result accumulation.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_cnt_d  = err_cnt_q;
    err_mask_d = err_mask_q;
    busy_d     = busy_q;
    done_d     = done_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_SETTLE;
          idx_d      = '0;
          cnt_d      = CNT_LOAD;
          err_cnt_d  = '0;
          err_mask_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end
      S_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (c_in != EXPECT[idx_q]) begin
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
            err_mask_d[idx_q] = 1'b1;
          end
          if (idx_q != IDX_W'(3)) begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = CNT_LOAD;
          end else begin
            state_d = S_DONE;
            idx_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Vector bits only drive the gate while a vector is being settled.
    a_out_d = (state_d == S_SETTLE) & idx_d[1];
    b_out_d = (state_d == S_SETTLE) & idx_d[0];
    pass_d  = done_d & (err_cnt_d == '0);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      err_cnt_q  <= '0;
      err_mask_q <= '0;
      a_out_q    <= 1'b0;
      b_out_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_mask_q <= err_mask_d;
      a_out_q    <= a_out_d;
      b_out_q    <= b_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign a_out    = a_out_q;
  assign b_out    = b_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign err_mask = err_mask_q;

endmodule
